// File: rtl/tetris_pkg.sv
// Shared field geometry and types for the settled-block playfield.
package tetris_pkg;

   localparam int COLS     = 10;
   localparam int ROWS     = 20;
   localparam int CELL_PX  = 24;
   localparam int FIELD_X0 = 200;
   localparam int FIELD_Y0 = 0;

   typedef enum logic [2:0] {
      IDLE,
      LOCK,
      SCAN,
      SHIFT,
      DONE
   } lock_state_t;

   typedef logic [COLS-1:0] grid_row_t;

endpackage

// File: rtl/pix_to_cell.sv
// Maps a piece cell's pixel centre to a grid (row, col), flagging positions
// that fall outside the field.
module pix_to_cell
   import tetris_pkg::*;
(
   input  logic [9:0] px_i,
   input  logic [9:0] py_i,
   output logic [4:0] row_o,
   output logic [3:0] col_o,
   output logic       valid_o
);

   logic [9:0] xoff;
   logic [9:0] yoff;

   // Floor division as a threshold count: the index is how many multiples of
   // CELL_PX the offset has reached. A count equal to COLS/ROWS means off-field.
   always_comb begin
      xoff  = px_i - 10'(FIELD_X0);
      yoff  = py_i - 10'(FIELD_Y0);
      col_o = '0;
      row_o = '0;
      for (int k = 1; k <= COLS; k++) begin
         if (xoff >= 10'(k * CELL_PX)) col_o = 4'(k);
      end
      for (int k = 1; k <= ROWS; k++) begin
         if (yoff >= 10'(k * CELL_PX)) row_o = 5'(k);
      end
      valid_o = (int'(px_i) >= FIELD_X0) && (int'(py_i) >= FIELD_Y0) &&
                (int'(col_o) < COLS) && (int'(row_o) < ROWS);
   end

endmodule

// File: rtl/playfield_lock.sv
// Settled-cell grid: locks a resting piece, clears full rows bottom-up,
// accumulates the line count and requests the next piece.
module playfield_lock
   import tetris_pkg::*;
(
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic        fell,
   input  logic [9:0]  blk1x,
   input  logic [9:0]  blk1y,
   input  logic [9:0]  blk2x,
   input  logic [9:0]  blk2y,
   input  logic [9:0]  blk3x,
   input  logic [9:0]  blk3y,
   input  logic [9:0]  blk4x,
   input  logic [9:0]  blk4y,
   input  logic [4:0]  rd_row,
   input  logic [3:0]  rd_col,
   output logic        rd_occ,
   output logic        busy,
   output logic        spawn,
   output logic [15:0] lines_total,
   output logic        game_over
);

   lock_state_t state_q;
   logic        fell_q;
   logic [9:0]  bx_q [4];
   logic [9:0]  by_q [4];
   grid_row_t   grid_q [ROWS];
   logic [4:0]  row_ptr_q;
   logic [2:0]  clr_cnt_q;
   logic [15:0] lines_q;
   logic        go_q;

   logic [9:0]  blk_x [4];
   logic [9:0]  blk_y [4];
   logic [4:0]  cell_row [4];
   logic [3:0]  cell_col [4];
   logic        cell_vld [4];

   logic        start;
   logic        row_full;
   logic [16:0] lines_sum;
   logic [15:0] lines_d;

   assign blk_x[0] = blk1x;
   assign blk_x[1] = blk2x;
   assign blk_x[2] = blk3x;
   assign blk_x[3] = blk4x;
   assign blk_y[0] = blk1y;
   assign blk_y[1] = blk2y;
   assign blk_y[2] = blk3y;
   assign blk_y[3] = blk4y;

   for (genvar i = 0; i < 4; i++) begin : g_cell
      pix_to_cell u_p2c (
         .px_i    (bx_q[i]),
         .py_i    (by_q[i]),
         .row_o   (cell_row[i]),
         .col_o   (cell_col[i]),
         .valid_o (cell_vld[i])
      );
   end

   // Edges arriving while busy or after game over are dropped, not queued.
   assign start     = fell & ~fell_q & (state_q == IDLE) & ~go_q;
   assign row_full  = &grid_q[row_ptr_q];
   assign lines_sum = {1'b0, lines_q} + 17'(clr_cnt_q);
   assign lines_d   = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         fell_q    <= 1'b0;
         row_ptr_q <= 5'(ROWS - 1);
         clr_cnt_q <= '0;
         lines_q   <= '0;
         go_q      <= 1'b0;
         for (int r = 0; r < ROWS; r++) grid_q[r] <= '0;
         for (int i = 0; i < 4; i++) begin
            bx_q[i] <= '0;
            by_q[i] <= '0;
         end
      end else begin
         fell_q <= fell;
         case (state_q)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < 4; i++) begin
                     bx_q[i] <= blk_x[i];
                     by_q[i] <= blk_y[i];
                  end
                  state_q <= LOCK;
               end
            end
            LOCK: begin
               // Collision is judged against the grid before this piece lands,
               // so repeated cells within one piece never trip game over.
               for (int i = 0; i < 4; i++) begin
                  if (cell_vld[i]) begin
                     if (grid_q[cell_row[i]][cell_col[i]]) go_q <= 1'b1;
                     grid_q[cell_row[i]][cell_col[i]] <= 1'b1;
                  end
               end
               clr_cnt_q <= '0;
               row_ptr_q <= 5'(ROWS - 1);
               state_q   <= SCAN;
            end
            SCAN: begin
               if (row_full)              state_q   <= SHIFT;
               else if (row_ptr_q == '0)  state_q   <= DONE;
               else                       row_ptr_q <= row_ptr_q - 5'd1;
            end
            SHIFT: begin
               // Row pointer is left alone so the row that dropped in is rescanned.
               for (int r = 1; r < ROWS; r++) begin
                  if (5'(r) <= row_ptr_q) grid_q[r] <= grid_q[r-1];
               end
               grid_q[0] <= '0;
               clr_cnt_q <= clr_cnt_q + 3'd1;
               state_q   <= SCAN;
            end
            DONE: begin
               lines_q <= lines_d;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy        = (state_q != IDLE);
   assign spawn       = (state_q == DONE);
   assign lines_total = lines_q;
   assign game_over   = go_q;
   assign rd_occ      = ((int'(rd_row) < ROWS) && (int'(rd_col) < COLS)) ?
                        grid_q[rd_row][rd_col] : 1'b0;

endmodule

// File: tb/tb_playfield_lock.sv
// Directed + randomized check of playfield_lock against an array-based model.
module tb_playfield_lock;

   localparam int R  = 20;
   localparam int C  = 10;
   localparam int X0 = 200;
   localparam int CP = 24;

   logic        frame_clk = 1'b0;
   logic        Reset = 1'b1;
   logic        fell = 1'b0;
   logic [9:0]  bx [4];
   logic [9:0]  by [4];
   logic [4:0]  rd_row = '0;
   logic [3:0]  rd_col = '0;
   logic        rd_occ, busy, spawn, game_over;
   logic [15:0] lines_total;

   int nvec = 0;
   int nerr = 0;

   bit mgrid [R][C];
   int mlines;
   bit mgo;

   playfield_lock dut (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .fell        (fell),
      .blk1x       (bx[0]),
      .blk1y       (by[0]),
      .blk2x       (bx[1]),
      .blk2y       (by[1]),
      .blk3x       (bx[2]),
      .blk3y       (by[2]),
      .blk4x       (bx[3]),
      .blk4y       (by[3]),
      .rd_row      (rd_row),
      .rd_col      (rd_col),
      .rd_occ      (rd_occ),
      .busy        (busy),
      .spawn       (spawn),
      .lines_total (lines_total),
      .game_over   (game_over)
   );

   always #5 frame_clk = ~frame_clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) mgrid[r][c] = 1'b0;
      mlines = 0;
      mgo    = 1'b0;
   endtask

   // Reference: drop the cells, then keep only non-full rows packed to the bottom.
   task automatic m_lock(output int clears);
      bit snap [R][C];
      bit ng [R][C];
      int x, y, dst;
      bit full;
      snap = mgrid;
      for (int i = 0; i < 4; i++) begin
         x = int'(bx[i]);
         y = int'(by[i]);
         if (x >= X0 && (x - X0) / CP < C && y / CP < R) begin
            if (snap[y / CP][(x - X0) / CP]) mgo = 1'b1;
            mgrid[y / CP][(x - X0) / CP] = 1'b1;
         end
      end
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) ng[r][c] = 1'b0;
      clears = 0;
      dst    = R - 1;
      for (int r = R - 1; r >= 0; r--) begin
         full = 1'b1;
         for (int c = 0; c < C; c++) if (!mgrid[r][c]) full = 1'b0;
         if (full) clears++;
         else begin
            for (int c = 0; c < C; c++) ng[dst][c] = mgrid[r][c];
            dst--;
         end
      end
      mgrid  = ng;
      mlines = (mlines + clears > 65535) ? 65535 : mlines + clears;
   endtask

   task automatic check_grid(input string tag);
      logic [C-1:0] ob, ex;
      for (int r = 0; r < R; r++) begin
         for (int c = 0; c < C; c++) begin
            rd_row = 5'(r);
            rd_col = 4'(c);
            #1;
            ob[c] = rd_occ;
            ex[c] = mgrid[r][c];
         end
         chk($sformatf("%s grid row %0d", tag, r), 32'(ob), 32'(ex));
      end
      rd_row = 5'd19;
      rd_col = 4'd12;
      #1;
      chk({tag, " rd out of range"}, 32'(rd_occ), 32'd0);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      fell  = 1'b0;
      @(posedge frame_clk); #1;
      Reset = 1'b0;
      m_reset();
   endtask

   task automatic set_cell(input int i, input int r, input int c);
      bx[i] = 10'(X0 + CP * c + CP / 2);
      by[i] = 10'(CP * r + CP / 2);
   endtask

   task automatic set_o_piece();
      bx[0] = 10'd320; by[0] = 10'd468;
      bx[1] = 10'd344; by[1] = 10'd468;
      bx[2] = 10'd320; by[2] = 10'd444;
      bx[3] = 10'd344; by[3] = 10'd444;
   endtask

   // Raise fell, hold it 'hold' cycles, then check timing and results.
   task automatic lock_piece(input string tag, input int hold);
      bit go0;
      int clr, spawn_at, nsp, b1, anyb;
      go0 = mgo;
      clr = 0;
      if (!go0) m_lock(clr);
      @(posedge frame_clk); #1;
      fell = 1'b1;
      spawn_at = -1; nsp = 0; b1 = 0; anyb = 0;
      for (int n = 1; n <= hold; n++) begin
         @(posedge frame_clk); #1;
         if (n == 1) b1 = int'(busy);
         if (busy !== 1'b0) anyb = 1;
         if (spawn === 1'b1) begin
            nsp++;
            if (spawn_at < 0) spawn_at = n;
         end
      end
      fell = 1'b0;
      repeat (2) @(posedge frame_clk);
      #1;
      if (go0) begin
         chk({tag, " busy after game over"}, 32'(anyb), 32'd0);
         chk({tag, " spawns after game over"}, 32'(nsp), 32'd0);
      end else begin
         chk({tag, " busy in cycle 1"}, 32'(b1), 32'd1);
         chk({tag, " spawn cycle"}, 32'(spawn_at), 32'(22 + 2 * clr));
         chk({tag, " spawn count"}, 32'(nsp), 32'd1);
      end
      chk({tag, " busy idle"}, 32'(busy), 32'd0);
      chk({tag, " lines_total"}, 32'(lines_total), 32'(mlines));
      chk({tag, " game_over"}, 32'(game_over), 32'(mgo));
      check_grid(tag);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         bx[i] = '0;
         by[i] = '0;
      end
      m_reset();
      repeat (2) @(posedge frame_clk);
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset spawn", 32'(spawn), 32'd0);
      chk("reset lines", 32'(lines_total), 32'd0);
      chk("reset game_over", 32'(game_over), 32'd0);
      Reset = 1'b0;
      check_grid("reset");

      // O piece on an empty field
      set_o_piece();
      lock_piece("t1 o piece", 40);

      // fell held for 100 cycles locks once
      do_reset();
      set_o_piece();
      lock_piece("t3 held fell", 100);

      // fill rows 18/19 except cols 5,6, then the O piece clears both
      do_reset();
      for (int row = 18; row <= 19; row++) begin
         set_cell(0, row, 0); set_cell(1, row, 1); set_cell(2, row, 2); set_cell(3, row, 3);
         lock_piece("t2 preload a", 40);
         set_cell(0, row, 4); set_cell(1, row, 7); set_cell(2, row, 8); set_cell(3, row, 9);
         lock_piece("t2 preload b", 40);
      end
      set_o_piece();
      lock_piece("t2 double clear", 40);

      // off-field cells are skipped
      bx[0] = 10'd190; by[0] = 10'd468;
      set_cell(1, 19, 0); set_cell(2, 19, 1); set_cell(3, 18, 0);
      lock_piece("t6 x below field", 40);
      bx[0] = 10'd212; by[0] = 10'd500;
      set_cell(1, 17, 9); set_cell(2, 16, 9); set_cell(3, 15, 9);
      lock_piece("t6 y below field", 40);

      // reset in the middle of SCAN
      set_o_piece();
      @(posedge frame_clk); #1;
      fell = 1'b1;
      repeat (10) @(posedge frame_clk);
      #1;
      chk("t5 busy in scan", 32'(busy), 32'd1);
      Reset = 1'b1;
      @(posedge frame_clk); #1;
      Reset = 1'b0;
      fell  = 1'b0;
      m_reset();
      chk("t5 busy", 32'(busy), 32'd0);
      chk("t5 spawn", 32'(spawn), 32'd0);
      chk("t5 lines", 32'(lines_total), 32'd0);
      chk("t5 game_over", 32'(game_over), 32'd0);
      check_grid("t5");

      // repeated cells are harmless, a real overlap is game over and sticks
      for (int i = 0; i < 4; i++) set_cell(i, 19, 5);
      lock_piece("t4 duplicate cells", 40);
      set_o_piece();
      lock_piece("t4 collision", 40);
      set_cell(0, 10, 0); set_cell(1, 10, 1); set_cell(2, 10, 2); set_cell(3, 10, 3);
      lock_piece("t4 after game over", 40);

      // random pieces concentrated on the bottom rows
      do_reset();
      for (int p = 0; p < 40; p++) begin
         for (int i = 0; i < 4; i++) begin
            int r, c;
            if ($urandom_range(0, 9) == 0) begin
               bx[i] = 10'($urandom_range(0, 1023));
               by[i] = 10'($urandom_range(0, 1023));
            end else begin
               r = 19; c = 0;
               for (int t = 0; t < 8; t++) begin
                  r = int'($urandom_range(16, 19));
                  c = int'($urandom_range(0, 9));
                  if (!mgrid[r][c]) break;
               end
               bx[i] = 10'(X0 + CP * c + int'($urandom_range(0, CP - 1)));
               by[i] = 10'(CP * r + int'($urandom_range(0, CP - 1)));
            end
         end
         lock_piece($sformatf("rand %0d", p), 40);
         if (mgo) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
